// File: rtl/regbank_write_scheduler.sv
// -----------------------------------------------------------------------------
// Module: regbank_write_scheduler
// Purpose:
//   Writer-side front end for the 32x32 register bank's single write port.
//   Accepts writeback results from the ALU and the load unit (valid/ready
//   handshakes). Queues them in order in a DEPTH-entry FIFO and drains one
//   entry per clock into the bank.
// Optional feature macro: WBQ_FWD_EN
//   When defined, two lookup ports expose queued-but-unwritten values to the
//   read-port consumers.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_valid/rd/data/ready    ALU writeback handshake
//   ld_valid/rd/data/ready     load writeback handshake
//   wr_en, wr_rd, wr_data      register bank write port (head of queue)
//   q_empty, q_count           queue status
//   fwd_ra/rb, fwd_*_hit/data  lookup ports (WBQ_FWD_EN only)
// -----------------------------------------------------------------------------
module regbank_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [4:0]    ld_rd,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    output logic          wr_en,
    output logic [4:0]    wr_rd,
    output logic [31:0]   wr_data,
    output logic          q_empty,
    output logic [AW:0]   q_count
`ifdef WBQ_FWD_EN
    ,
    input  logic [4:0]    fwd_ra,
    input  logic [4:0]    fwd_rb,
    output logic          fwd_a_hit,
    output logic [31:0]   fwd_a_data,
    output logic          fwd_b_hit,
    output logic [31:0]   fwd_b_data
`endif
);

    logic [4:0]    ent_rd_q   [DEPTH];
    logic [4:0]    ent_rd_d   [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   free;
    logic [AW-1:0] ld_slot;
    logic          alu_push;
    logic          ld_push;
    logic          pop;

    // Free slots come from the registered count only, so ready never
    // depends on the same-cycle pop.
    assign free      = (AW+1)'(DEPTH) - count_q;
    assign ld_ready  = (free != '0);
    // The load gets the last free slot when both producers want it.
    assign alu_ready = (free >= (AW+1)'(2)) || ((free == (AW+1)'(1)) && !ld_valid);

    // Writes to R0 complete the handshake but never occupy a slot.
    assign alu_push  = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign ld_push   = ld_valid  && ld_ready  && (ld_rd  != 5'd0);

    // The bank never stalls, so any occupied head drains every cycle.
    assign pop       = (count_q != '0);
    assign wr_en     = pop;
    assign q_empty   = (count_q == '0);
    assign q_count   = count_q;
    assign wr_rd     = wr_en ? ent_rd_q[rp_q]   : 5'd0;
    assign wr_data   = wr_en ? ent_data_q[rp_q] : 32'd0;

    // When both producers push, the ALU entry is older and takes wp.
    assign ld_slot   = wp_q + AW'(alu_push);

    always_comb begin
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        if (alu_push) begin
            ent_rd_d[wp_q]   = alu_rd;
            ent_data_d[wp_q] = alu_data;
        end
        if (ld_push) begin
            ent_rd_d[ld_slot]   = ld_rd;
            ent_data_d[ld_slot] = ld_data;
        end
        wp_d    = wp_q + AW'(alu_push) + AW'(ld_push);
        rp_d    = rp_q + AW'(pop);
        count_d = count_q + (AW+1)'(alu_push) + (AW+1)'(ld_push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= 5'd0;
                ent_data_q[i] <= 32'd0;
            end
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
        end
    end

`ifdef WBQ_FWD_EN
    logic [AW-1:0] fwd_slot;

    // Walk from oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_a_data = 32'd0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = 32'd0;
        fwd_slot   = rp_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_slot = rp_q + AW'(i);
            if ((AW+1)'(i) < count_q) begin
                if ((fwd_ra != 5'd0) && (ent_rd_q[fwd_slot] == fwd_ra)) begin
                    fwd_a_hit  = 1'b1;
                    fwd_a_data = ent_data_q[fwd_slot];
                end
                if ((fwd_rb != 5'd0) && (ent_rd_q[fwd_slot] == fwd_rb)) begin
                    fwd_b_hit  = 1'b1;
                    fwd_b_data = ent_data_q[fwd_slot];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench: tb_regbank_write_scheduler
// Purpose:
//   Self-checking bench for regbank_write_scheduler. A queue-based reference
//   model tracks pending writes; every cycle all outputs are compared against
//   it, and directed steps add explicit expectations for the key scenarios.
//   Lookup ports are exercised when WBQ_FWD_EN is defined.
// -----------------------------------------------------------------------------
module tb_regbank_write_scheduler;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        q_empty;
    logic [2:0]  q_count;
    logic [4:0]  fwd_ra;
    logic [4:0]  fwd_rb;
`ifdef WBQ_FWD_EN
    logic        fwd_a_hit;
    logic [31:0] fwd_a_data;
    logic        fwd_b_hit;
    logic [31:0] fwd_b_data;
`endif

    ent_t model_q[$];
    logic exp_alu_ready;
    logic exp_ld_ready;
    int   checks = 0;
    int   errors = 0;

    regbank_write_scheduler #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .wr_en      (wr_en),
        .wr_rd      (wr_rd),
        .wr_data    (wr_data),
        .q_empty    (q_empty),
        .q_count    (q_count)
`ifdef WBQ_FWD_EN
        ,
        .fwd_ra     (fwd_ra),
        .fwd_rb     (fwd_rb),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_b_data (fwd_b_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Youngest pending value for a tag, 0 when no hit or tag is R0.
    task automatic modelLookup(input logic [4:0] tag, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = 32'd0;
        if (tag != 5'd0) begin
            foreach (model_q[i]) begin
                if (model_q[i].rd == tag) begin
                    hit = 1'b1;
                    val = model_q[i].data;
                end
            end
        end
    endtask

    // Compare every output against the model for the currently driven inputs.
    task automatic checkOutput();
        int          free;
        logic        h;
        logic [31:0] v;
        free          = 4 - model_q.size();
        exp_ld_ready  = (free >= 1);
        exp_alu_ready = (free >= 2) || (free == 1 && !ld_valid);
        checkVal("ld_ready",  {31'd0, ld_ready},  {31'd0, exp_ld_ready});
        checkVal("alu_ready", {31'd0, alu_ready}, {31'd0, exp_alu_ready});
        checkVal("q_count",   {29'd0, q_count},   model_q.size());
        checkVal("q_empty",   {31'd0, q_empty},   {31'd0, (model_q.size() == 0)});
        checkVal("wr_en",     {31'd0, wr_en},     {31'd0, (model_q.size() != 0)});
        checkVal("wr_rd",     {27'd0, wr_rd},     (model_q.size() != 0) ? {27'd0, model_q[0].rd} : 32'd0);
        checkVal("wr_data",   wr_data,            (model_q.size() != 0) ? model_q[0].data : 32'd0);
`ifdef WBQ_FWD_EN
        modelLookup(fwd_ra, h, v);
        checkVal("fwd_a_hit",  {31'd0, fwd_a_hit}, {31'd0, h});
        checkVal("fwd_a_data", fwd_a_data, v);
        modelLookup(fwd_rb, h, v);
        checkVal("fwd_b_hit",  {31'd0, fwd_b_hit}, {31'd0, h});
        checkVal("fwd_b_data", fwd_b_data, v);
`else
        modelLookup(fwd_ra, h, v);
`endif
    endtask

    // Drive inputs on the falling edge, then check before the rising edge.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                 input logic [4:0] fa, input logic [4:0] fb);
        @(negedge clk);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldat;
        fwd_ra    = fa;
        fwd_rb    = fb;
        #1;
        checkOutput();
    endtask

    // Take the rising edge and apply the same transfer to the model.
    task automatic advance();
        ent_t e;
        @(posedge clk);
        if (model_q.size() != 0) void'(model_q.pop_front());
        if (alu_valid && exp_alu_ready && alu_rd != 5'd0) begin
            e.rd = alu_rd; e.data = alu_data; model_q.push_back(e);
        end
        if (ld_valid && exp_ld_ready && ld_rd != 5'd0) begin
            e.rd = ld_rd; e.data = ld_data; model_q.push_back(e);
        end
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        advance();
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'd0;
        fwd_ra = 5'd0; fwd_rb = 5'd0;

        // Reset values.
        #1;
        checkOutput();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single ALU write: visible next cycle, drained the cycle after.
        applyStimulus(1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkVal("dir_rd5_count", {29'd0, q_count}, 32'd1);
        checkVal("dir_rd5_wr_rd", {27'd0, wr_rd},   32'd5);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkVal("dir_rd5_empty", {31'd0, q_empty}, 32'd1);
        advance();

        // Both ports into an empty queue: ALU first, then load.
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0);
        checkVal("dir_both_alu_rdy", {31'd0, alu_ready}, 32'd1);
        checkVal("dir_both_ld_rdy",  {31'd0, ld_ready},  32'd1);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkVal("dir_both_first", wr_data, 32'h11);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkVal("dir_both_second", wr_data, 32'h22);
        advance();
        idleStep();

        // Producers held valid for 10 cycles: count bounded, load wins last slot.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 5'(8 + i), 32'h100 + i, 1'b1, 5'(20 + i), 32'h200 + i, 5'd0, 5'd0);
            checkVal("hold_count_le4", {31'd0, (q_count <= 3'd4)}, 32'd1);
            if (model_q.size() == 3) begin
                checkVal("hold_free1_ld_rdy",  {31'd0, ld_ready},  32'd1);
                checkVal("hold_free1_alu_rdy", {31'd0, alu_ready}, 32'd0);
            end
            advance();
        end
        repeat (5) idleStep();

        // R0 handshake: accepted, nothing queued, no write.
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkVal("r0_alu_rdy", {31'd0, alu_ready}, 32'd1);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkVal("r0_count", {29'd0, q_count}, 32'd0);
        checkVal("r0_wr_en", {31'd0, wr_en},   32'd0);
        advance();

        // Two writes to R7 pending together: youngest value forwarded.
        applyStimulus(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd0, 5'd0);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
`ifdef WBQ_FWD_EN
        checkVal("fwd_dir_a_hit",  {31'd0, fwd_a_hit}, 32'd1);
        checkVal("fwd_dir_a_data", fwd_a_data,         32'h2);
        checkVal("fwd_dir_b_hit",  {31'd0, fwd_b_hit}, 32'd0);
`endif
        checkVal("dup_first_write", wr_data, 32'h1);
        advance();
        repeat (3) idleStep();

        // Randomized traffic with a small register range to force collisions.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            advance();
        end
        repeat (5) idleStep();

        // Reset with three entries pending discards them at once.
        applyStimulus(1'b1, 5'd1, 32'hC1, 1'b1, 5'd2, 32'hC2, 5'd0, 5'd0);
        advance();
        applyStimulus(1'b1, 5'd3, 32'hC3, 1'b1, 5'd4, 32'hC4, 5'd0, 5'd0);
        advance();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkVal("pre_reset_count", {29'd0, q_count}, 32'd3);
        rst_n = 1'b0;
        #1;
        model_q.delete();
        checkVal("rst_wr_en",   {31'd0, wr_en},   32'd0);
        checkVal("rst_count",   {29'd0, q_count}, 32'd0);
        checkVal("rst_empty",   {31'd0, q_empty}, 32'd1);
        checkVal("rst_wr_data", wr_data,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
            checkVal("post_reset_no_wr", {31'd0, wr_en}, 32'd0);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
